// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   dmem_state_t  - responder FSM states (IDLE, WAIT, RESP)
//   DMEM_ERR_DATA - load data returned for an illegal access
//   word_index    - byte address -> word index, masked to the array width
//   addr_illegal  - misaligned or out-of-range access test
// Bus command encodings normally come from sys_defs.vh; the guarded defaults
// below match it so this slice builds stand-alone.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

  // Word index is addr[aw+1:2]; upper bits dropped so the array wraps.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

  function automatic logic addr_illegal(input logic [31:0] addr,
                                        input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage with synchronous write and a
// registered read index (read data is the word at the captured index).
//   clk        - clock
//   we         - write enable, writes wdata to mem[idx]
//   rd_capture - captures idx as the read index
//   idx        - shared word index for write and read capture
//   wdata      - write data
//   rdata      - word at the captured read index
// Contents are not reset.
module dmem_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          rd_capture,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] rd_idx_q;

  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= wdata;
    if (rd_capture)
      rd_idx_q <= idx;
  end

  assign rdata = mem[rd_idx_q];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the proc2Dmem/Dmem2proc bus.
// Stores complete in one cycle; loads respond after LAT cycles with busy held
// while the load waits.
//   clk, rst          - clock; asynchronous active-low reset
//   proc2Dmem_command - BUS_NONE / BUS_LOAD / BUS_STORE
//   proc2Dmem_addr    - byte address (word index addr[AW+1:2])
//   proc2Dmem_data    - store data
//   Dmem2proc_data    - load data, held until the next response
//   Dmem2proc_valid   - one-cycle load-response strobe
//   Dmem2proc_busy    - load in flight
//   Dmem2proc_err     - illegal-access strobe
// Optional macro DMEM_ERR_CHECK_EN: reject misaligned/out-of-range accesses;
// when undefined the address wraps and Dmem2proc_err is tied 0.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  output logic [31:0] Dmem2proc_data,
  output logic        Dmem2proc_valid,
  output logic        Dmem2proc_busy,
  output logic        Dmem2proc_err
);
  import dmem_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hold_q;
  logic [AW-1:0] idx;
  logic [31:0]   rd_data;
  logic [31:0]   resp_data;
  logic          can_accept;
  logic          is_load;
  logic          is_store;
  logic          bad;

  assign idx        = AW'(word_index(proc2Dmem_addr, AW));
  assign can_accept = (state_q == IDLE) || (state_q == RESP);
  assign is_load    = can_accept && (proc2Dmem_command == `BUS_LOAD);
  assign is_store   = can_accept && (proc2Dmem_command == `BUS_STORE);

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk       (clk),
    .we        (is_store && !bad),
    .rd_capture(is_load),
    .idx       (idx),
    .wdata     (proc2Dmem_data),
    .rdata     (rd_data)
  );

  // WAIT holds LAT-1 cycles: the counter is loaded with LAT-1 and RESP follows
  // the edge on which it decrements to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (is_load) begin
          state_d = (LAT == 1) ? RESP : WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Keep the response word visible after RESP until the next response.
      if (state_q == RESP)
        hold_q <= resp_data;
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  logic load_bad_q;
  logic store_err_q;

  assign bad = addr_illegal(proc2Dmem_addr, AW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_bad_q  <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      if (is_load)
        load_bad_q <= bad;
      store_err_q <= is_store && bad;
    end
  end

  assign resp_data     = load_bad_q ? DMEM_ERR_DATA : rd_data;
  assign Dmem2proc_err = store_err_q || ((state_q == RESP) && load_bad_q);
`else
  assign bad           = 1'b0;
  assign resp_data     = rd_data;
  assign Dmem2proc_err = 1'b0;
`endif

  assign Dmem2proc_valid = (state_q == RESP);
  assign Dmem2proc_busy  = (state_q == WAIT);
  assign Dmem2proc_data  = (state_q == RESP) ? resp_data : hold_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: four responders (LAT = 1..4, DEPTH_WORDS = 1024) run side
// by side. A timestamp-based memory model predicts every output each cycle;
// a vector table and hand sequences cover the documented corner cases.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

module tb_dmem_responder;

  localparam int NL = 4;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd   [NL];
  logic [31:0] addr  [NL];
  logic [31:0] wdata [NL];
  logic [31:0] rdata [NL];
  logic        valid [NL];
  logic        busy  [NL];
  logic        err   [NL];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(1024), .LAT(g + 1)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .proc2Dmem_command(cmd[g]),
      .proc2Dmem_addr   (addr[g]),
      .proc2Dmem_data   (wdata[g]),
      .Dmem2proc_data   (rdata[g]),
      .Dmem2proc_valid  (valid[g]),
      .Dmem2proc_busy   (busy[g]),
      .Dmem2proc_err    (err[g])
    );
  end

  int vectors    = 0;
  int miscompares = 0;
  int n = 0;  // number of rising edges so far

  // Reference model: per lane, memory plus the edge at which the last load
  // was accepted; all timing follows from that edge and the lane's latency.
  logic [31:0] mem_m [NL][1024];
  bit          has_load  [NL];
  int          acc_e     [NL];
  int          free_from [NL];
  logic [31:0] ld_val    [NL];
  bit          ld_bad    [NL];
  logic [31:0] held      [NL];
  int          st_err_e  [NL];

  function automatic bit illegal(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return ((a % 4) != 0) || (a >= 32'h1000);
`else
    return (a != a);
`endif
  endfunction

  task automatic model_reset(input int i);
    has_load[i]  = 0;
    acc_e[i]     = 0;
    free_from[i] = 0;
    ld_val[i]    = '0;
    ld_bad[i]    = 0;
    held[i]      = '0;
    st_err_e[i]  = -10;
  endtask

  task automatic model_edge(input int i);
    int lat;
    int idx;
    bit bad;
    lat = i + 1;
    idx = int'((addr[i] / 4) % 1024);
    bad = illegal(addr[i]);
    if (n >= free_from[i] && cmd[i] != `BUS_NONE) begin
      if (cmd[i] == `BUS_STORE) begin
        if (bad) st_err_e[i] = n;
        else     mem_m[i][idx] = wdata[i];
      end else if (cmd[i] == `BUS_LOAD) begin
        if (has_load[i]) held[i] = ld_val[i];
        has_load[i]  = 1;
        acc_e[i]     = n;
        free_from[i] = n + lat;
        ld_bad[i]    = bad;
        ld_val[i]    = bad ? ERR_WORD : mem_m[i][idx];
      end
    end
  endtask

  function automatic logic [34:0] exp_vec(input int i);
    int lat;
    logic v, b, e;
    logic [31:0] d;
    lat = i + 1;
    v = has_load[i] && (n == acc_e[i] + lat - 1);
    b = has_load[i] && (n >= acc_e[i]) && (n <= acc_e[i] + lat - 2);
    e = (st_err_e[i] == n) || (v && ld_bad[i]);
    d = (has_load[i] && n >= acc_e[i] + lat - 1) ? ld_val[i] : held[i];
    return {v, b, e, d};
  endfunction

  function automatic logic [34:0] act_vec(input int i);
    return {valid[i], busy[i], err[i], rdata[i]};
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got v/b/e/data=%h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < NL; i++) begin
      cmd[i]   = `BUS_NONE;
      addr[i]  = '0;
      wdata[i] = '0;
    end
  endtask

  task automatic put(input int l, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    cmd[l]   = c;
    addr[l]  = a;
    wdata[l] = d;
  endtask

  // One clock: model sees the inputs at the rising edge, outputs are
  // compared at the following falling edge.
  task automatic tick();
    @(posedge clk);
    n++;
    for (int i = 0; i < NL; i++) begin
      if (!rst) model_reset(i);
      else      model_edge(i);
    end
    @(negedge clk);
    for (int i = 0; i < NL; i++)
      check($sformatf("model_lane%0d_edge%0d", i, n), act_vec(i), exp_vec(i));
  endtask

  function automatic logic [31:0] init_val(input int l, input int w);
    return 32'h1000_0000 | (32'(l) << 8) | 32'(w);
  endfunction

  typedef struct {
    int          lane;
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic        ev;
    logic        eb;
    logic [31:0] ed;
    bit          chk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int l, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                     input logic ev, input logic eb, input logic [31:0] ed, input bit chk);
    vec_t v;
    v.lane = l; v.c = c; v.a = a; v.d = d; v.ev = ev; v.eb = eb; v.ed = ed; v.chk = chk;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    for (int i = 0; i < NL; i++) model_reset(i);

    // Reset state
    tick();
    tick();
    for (int i = 0; i < NL; i++)
      check($sformatf("reset_lane%0d", i), act_vec(i), 35'h0);
    rst = 1'b1;

    // Fill words 0..31 of every lane with a known pattern
    for (int w = 0; w < 32; w++) begin
      for (int i = 0; i < NL; i++) put(i, `BUS_STORE, 32'(w) << 2, init_val(i, w));
      tick();
    end
    idle_all();
    tick();

    // LAT=2: store then load next cycle
    add(1, `BUS_STORE, 32'h10, 32'hCAFE_0001, 0, 0, 32'h0, 1);
    add(1, `BUS_LOAD,  32'h10, 32'h0,         0, 1, 32'h0, 0);
    add(1, `BUS_NONE,  32'h0,  32'h0,         1, 0, 32'hCAFE_0001, 1);
    add(1, `BUS_NONE,  32'h0,  32'h0,         0, 0, 32'hCAFE_0001, 1);
    // LAT=1: back-to-back loads, one response per cycle
    add(0, `BUS_STORE, 32'h0, 32'd1, 0, 0, 32'h0, 0);
    add(0, `BUS_STORE, 32'h4, 32'd2, 0, 0, 32'h0, 0);
    add(0, `BUS_STORE, 32'h8, 32'd3, 0, 0, 32'h0, 0);
    add(0, `BUS_STORE, 32'hC, 32'd4, 0, 0, 32'h0, 0);
    add(0, `BUS_LOAD,  32'h0, 32'h0, 1, 0, 32'd1, 1);
    add(0, `BUS_LOAD,  32'h4, 32'h0, 1, 0, 32'd2, 1);
    add(0, `BUS_LOAD,  32'h8, 32'h0, 1, 0, 32'd3, 1);
    add(0, `BUS_LOAD,  32'hC, 32'h0, 1, 0, 32'd4, 1);
    add(0, `BUS_NONE,  32'h0, 32'h0, 0, 0, 32'd4, 1);
    // LAT=4: store held on the bus during WAIT is ignored, then accepted
    add(3, `BUS_LOAD,  32'h20, 32'h0,  0, 1, 32'h0, 0);
    add(3, `BUS_STORE, 32'h20, 32'h55, 0, 1, 32'h0, 0);
    add(3, `BUS_STORE, 32'h20, 32'h55, 0, 1, 32'h0, 0);
    add(3, `BUS_STORE, 32'h20, 32'h55, 1, 0, init_val(3, 8), 1);
    add(3, `BUS_STORE, 32'h20, 32'h55, 0, 0, init_val(3, 8), 1);
    add(3, `BUS_LOAD,  32'h20, 32'h0,  0, 1, 32'h0, 0);
    add(3, `BUS_NONE,  32'h0,  32'h0,  0, 1, 32'h0, 0);
    add(3, `BUS_NONE,  32'h0,  32'h0,  0, 1, 32'h0, 0);
    add(3, `BUS_NONE,  32'h0,  32'h0,  1, 0, 32'h55, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      int l;
      l = tbl[k].lane;
      idle_all();
      put(l, tbl[k].c, tbl[k].a, tbl[k].d);
      tick();
      check($sformatf("tbl%0d_lane%0d", k, l),
            {valid[l], busy[l], err[l], tbl[k].chk ? rdata[l] : 32'h0},
            {tbl[k].ev, tbl[k].eb, 1'b0, tbl[k].chk ? tbl[k].ed : 32'h0});
    end
    idle_all();
    tick();

    // LAT=3: reset pulse during WAIT aborts the load, prior store survives
    put(2, `BUS_STORE, 32'h40, 32'hA5A5_0040);
    tick();
    put(2, `BUS_LOAD, 32'h40, 32'h0);
    tick();
    check("rst_seq_busy", {31'h0, busy[2], err[2], valid[2], 1'b0}, {31'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    idle_all();
    rst = 1'b0;
    #1;
    check("rst_async_outputs", act_vec(2), 35'h0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_no_valid%0d", k), act_vec(2), 35'h0);
    end
    put(2, `BUS_LOAD, 32'h40, 32'h0);
    tick();
    idle_all();
    tick();
    tick();
    check("rst_store_kept", act_vec(2), {1'b1, 1'b0, 1'b0, 32'hA5A5_0040});
    tick();

`ifdef DMEM_ERR_CHECK_EN
    // Misaligned store is rejected; out-of-range load returns the error word
    put(1, `BUS_STORE, 32'h2, 32'h99);
    tick();
    check("err_store_strobe", {34'h0, err[1]}, 35'h1);
    idle_all();
    tick();
    check("err_store_clear", {34'h0, err[1]}, 35'h0);
    put(1, `BUS_LOAD, 32'h0, 32'h0);
    tick();
    idle_all();
    tick();
    check("err_store_unchanged", act_vec(1), {1'b1, 1'b0, 1'b0, init_val(1, 0)});
    put(1, `BUS_LOAD, 32'h0010_0000, 32'h0);
    tick();
    idle_all();
    tick();
    check("err_load_resp", act_vec(1), {1'b1, 1'b0, 1'b1, ERR_WORD});
    tick();
`else
    // Upper address bits ignored: 0x1000 wraps onto word 0
    put(1, `BUS_STORE, 32'h1000, 32'h77);
    tick();
    put(1, `BUS_LOAD, 32'h0, 32'h0);
    tick();
    idle_all();
    tick();
    check("wrap_load", act_vec(1), {1'b1, 1'b0, 1'b0, 32'h77});
    tick();
`endif

    // Random traffic, including commands held while busy
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NL; i++) begin
        int unsigned r;
        logic [31:0] a;
        a = 32'($urandom_range(0, 31)) << 2;
        r = $urandom_range(0, 9);
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        if (r == 1) a = a | 32'h1000;
        if (r == 2) a = a | 32'h0010_0000;
        r = $urandom_range(0, 9);
        put(i, (r < 4) ? `BUS_NONE : ((r < 7) ? `BUS_LOAD : `BUS_STORE), a, $urandom());
      end
      tick();
    end
    idle_all();
    for (int k = 0; k < 6; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
